// File: rtl/hex_disp_pkg.sv
// Shared constants and types for the hex display controller.
// Holds the blank pattern, the gfedcba active-low code table and FSM states.
package hex_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 0 is the rightmost entry; entry n is the code for hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {
    IDLE,
    UPDATE
  } state_t;

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to 7-segment (gfedcba, active-low) decoder.
// Ports: nib (4-bit digit in), seg (7-bit pattern out).
module hex_seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/hex_display_ctrl.sv
// Multi-digit hex display controller: one shared decoder, one digit per cycle.
// Ports: clk, rst_n, load_valid/load_ready/load_data, blank, busy, seg_out.
// Option: define HEX_DISP_LZ_BLANK_EN for leading-zero blanking.
module hex_display_ctrl
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    blank,
  output logic                    busy,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  localparam int IW =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [IW-1:0]           idx;
  logic                    blank_q;
  logic [7*NUM_DIGITS-1:0] seg_reg;
  logic [3:0]              nib;
  logic [6:0]              dec;
  logic [6:0]              pat;
  logic                    sup;
  logic                    accept;

  assign accept = (state == IDLE) && load_valid;

  always_comb begin
    nib = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) nib = shadow[4*i +: 4];
    end
  end

  hex_seg_decode u_dec (
    .nib (nib),
    .seg (dec)
  );

`ifdef HEX_DISP_LZ_BLANK_EN
  // lz[i]: nibbles i..top are all zero; bit 0 stays clear so 0 shows "0".
  logic [NUM_DIGITS-1:0] lz;

  always_comb begin
    logic acc;
    acc = 1'b1;
    lz  = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      acc   = acc && (shadow[4*i +: 4] == 4'h0);
      lz[i] = acc;
    end
  end

  always_comb begin
    sup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) sup = lz[i];
    end
  end
`else
  assign sup = 1'b0;
`endif

  assign pat = sup ? SEG_BLANK : dec;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load_valid) state_nxt = UPDATE;
      UPDATE:  if (idx == LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shadow  <= '0;
      idx     <= '0;
      blank_q <= 1'b0;
      seg_reg <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      state   <= state_nxt;
      blank_q <= blank;
      if (accept) begin
        shadow <= load_data;
        idx    <= '0;
      end
      if (state == UPDATE) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (idx == IW'(i)) seg_reg[7*i +: 7] <= pat;
        end
        idx <= idx + 1'b1;
      end
    end
  end

  assign load_ready = (state == IDLE);
  assign busy       = (state == UPDATE);
  assign seg_out    =
    blank_q ? {NUM_DIGITS{SEG_BLANK}} : seg_reg;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl against a per-edge digit model.
// Honours HEX_DISP_LZ_BLANK_EN to match the DUT build.
module tb_hex_display_ctrl;

  localparam int ND = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            load_valid;
  logic            load_ready;
  logic [4*ND-1:0] load_data;
  logic            blank;
  logic            busy;
  logic [7*ND-1:0] seg_out;

  int checks   = 0;
  int failures = 0;

  logic [6:0]      cur [ND];
  logic [4*ND-1:0] sh;
  int              pend;
  logic            blank_m;

  hex_display_ctrl #(.NUM_DIGITS(ND)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank      (blank),
    .busy       (busy),
    .seg_out    (seg_out)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0011000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [6:0] model_pat(
    input logic [4*ND-1:0] v, input int i);
    logic [4*ND-1:0] hi;
    hi = v >> (4 * i);
`ifdef HEX_DISP_LZ_BLANK_EN
    if (i > 0 && hi == '0) return 7'h7F;
`endif
    return enc(hi[3:0]);
  endfunction

  function automatic logic [7*ND-1:0] exp_seg();
    logic [7*ND-1:0] r;
    for (int i = 0; i < ND; i++)
      r[7*i +: 7] = blank_m ? 7'h7F : cur[i];
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("seg_out", 32'(seg_out), 32'(exp_seg()));
    chk("load_ready", 32'(load_ready), 32'(pend == 0));
    chk("busy", 32'(busy), 32'(pend > 0));
  endtask

  task automatic model_reset();
    for (int i = 0; i < ND; i++) cur[i] = 7'h7F;
    pend    = 0;
    sh      = '0;
    blank_m = 1'b0;
  endtask

  task automatic tick();
    logic            acc;
    logic [4*ND-1:0] ld;
    logic            bl;
    acc = (pend == 0) && load_valid && rst_n;
    ld  = load_data;
    bl  = blank;
    @(posedge clk);
    if (rst_n) begin
      if (pend > 0) begin
        cur[ND - pend] = model_pat(sh, ND - pend);
        pend--;
      end else if (acc) begin
        sh   = ld;
        pend = ND;
      end
      blank_m = bl;
    end
    #1;
    check_all();
  endtask

  task automatic do_load(input logic [4*ND-1:0] v);
    load_valid = 1'b1;
    load_data  = v;
    tick();
    load_valid = 1'b0;
    repeat (ND + 1) tick();
  endtask

  initial begin
    logic [7*ND-1:0] k;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    blank      = 1'b0;
    model_reset();
    #12;
    chk("rst_seg", 32'(seg_out), 32'h0FFFFFFF);
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) tick();

    do_load(16'h0123);
    do_load(16'h4444);
    for (int i = 0; i < ND; i++) k[7*i +: 7] = 7'h19;
    chk("all_four", 32'(seg_out), 32'(k));
    do_load(16'hABCD);
    do_load(16'hEF89);
    do_load(16'h4567);

    // second load held during UPDATE is taken at the first IDLE edge
    load_valid = 1'b1;
    load_data  = 16'h1234;
    tick();
    load_data  = 16'hFFFF;
    repeat (ND + 1) tick();
    load_valid = 1'b0;
    repeat (ND + 2) tick();
    for (int i = 0; i < ND; i++) k[7*i +: 7] = 7'h0E;
    chk("hold_ffff", 32'(seg_out), 32'(k));

    // blank for five cycles in the middle of an update
    load_valid = 1'b1;
    load_data  = 16'h9876;
    tick();
    load_valid = 1'b0;
    tick();
    blank = 1'b1;
    repeat (5) tick();
    blank = 1'b0;
    repeat (2) tick();

    // reset at update cycle 2
    load_valid = 1'b1;
    load_data  = 16'h5A5A;
    tick();
    load_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_seg", 32'(seg_out), 32'h0FFFFFFF);
    check_all();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

`ifdef HEX_DISP_LZ_BLANK_EN
    do_load(16'h0050);
    chk("lz_0050", 32'(seg_out),
        32'({7'h7F, 7'h7F, 7'h12, 7'h40}));
    do_load(16'h0000);
`endif

    for (int n = 0; n < 300; n++) begin
      load_valid = ($urandom_range(0, 2) != 0);
      load_data  = 16'($urandom);
      if (n % 40 == 0) load_data = 16'($urandom_range(0, 255));
      blank      = ($urandom_range(0, 7) == 0);
      tick();
    end
    load_valid = 1'b0;
    blank      = 1'b0;
    repeat (ND + 2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Loads a multi-digit hex value through a valid/ready handshake.
- Sequences one shared hex-to-7-segment decoder across all digits, one digit per cycle.
- Holds the decoded patterns in per-digit output registers that drive the board's HEX displays.
- Sits between user logic and the seven-segment pins; segments are active-low.

Parameters:
- NUM_DIGITS, 4: number of displayed hex digits (1..8).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  controller can accept a load.
- load_data  in  4*NUM_DIGITS  digit i = load_data[4i+3:4i]; digit 0 is rightmost.
- blank  in  1  force every segment off while high.
- busy  out  1  update sequence in progress.
- seg_out  out  7*NUM_DIGITS  digit i = seg_out[7i+6:7i], bit order gfedcba, active-low.

Behaviour:
- One clock domain, clk. rst_n is asynchronous active-low.
- Reset values:
  - state = IDLE, shadow = 0, idx = 0, blank_q = 0.
  - Every seg_reg digit = 7'h7F (all segments off).
  - load_ready = 1, busy = 0.
  - Reset asserted mid-update aborts the update immediately; all digits go off.
- State IDLE:
  - load_ready = 1, busy = 0.
  - Accept happens on a rising edge where load_valid && load_ready is high, at edge T.
  - At edge T: shadow <= load_data, idx <= 0, state <= UPDATE.
- State UPDATE:
  - load_ready = 0, busy = 1.
  - Decoder input is shadow nibble idx.
  - Each edge: seg_reg[idx] <= decoded pattern, idx <= idx+1.
  - Digit i is written at edge T+1+i.
  - At edge T+NUM_DIGITS (last digit written) state <= IDLE.
  - load_ready returns to 1 in the cycle after edge T+NUM_DIGITS.
- Loads presented during UPDATE are not accepted. The source must hold load_valid high; it is accepted at the first IDLE edge.
- Back-to-back loads: accepts are at most one per NUM_DIGITS+1 cycles.
- Digits not yet rewritten during UPDATE keep their previous value, so the display shows a transient mix of old and new digits.
- Decoder codes (gfedcba, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=18, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
  - Digit 4 shall be 7'b0011001.
- blank:
  - blank_q <= blank each edge.
  - seg_out = blank_q ? all 7'h7F : seg_reg, so blank takes effect one cycle after it changes.
  - Updates continue while blanked; contents reappear intact when blank is released.
- Simultaneous accept and blank: both take effect independently.

Optional Feature:
- Macro: HEX_DISP_LZ_BLANK_EN.
- Defined: leading-zero blanking.
  - During UPDATE, digit i > 0 is written as 7'h7F if shadow nibbles i..NUM_DIGITS-1 are all zero.
  - The mask is computed combinationally from shadow.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
  - Timing is unchanged.
- Undefined: every digit is decoded, including leading zeros.

Decomposition:
- Package hex_disp_pkg holds:
  - SEG_BLANK = 7'h7F.
  - The 16-entry segment code constant table.
  - The state enum {IDLE, UPDATE}.
- One sub-module, hex_seg_decode: combinational 4-bit in to 7-bit active-low out, using the package table. It is instantiated exactly once and shared by all digits.

Test Plan:
- Reset, then release rst_n -> seg_out = 28'hFFFFFFF, load_ready = 1, busy = 0.
- Load 16'h0123 accepted at edge T:
  - busy = 1 for 4 cycles.
  - seg_out digit0 = 30 at T+1, digit1 = 24 at T+2, digit2 = 79 at T+3, digit3 = 40 at T+4.
  - load_ready = 1 after T+4.
- Sweep 0..F in all digits (e.g. 16'h4444, 16'hABCD) -> every code matches the table; 16'h4444 gives 19 on all four digits.
- Hold load_valid during UPDATE with a second value 16'hFFFF -> not accepted until IDLE, then all digits = 0E; no load lost or duplicated.
- Assert blank for 5 cycles mid-update -> all segments 7F one cycle after assertion; on release, digits show the completed new value.
- Assert rst_n low at update cycle 2 -> all digits 7F immediately. With HEX_DISP_LZ_BLANK_EN, load 16'h0050 -> digits 3,2 = 7F, digit1 = 12, digit0 = 40.
